// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
//  Module   : div_unit
//  Purpose  : Iterative RV32M DIV/DIVU/REM/REMU unit with request/done
//             completion handshake and metadata passthrough.
//  Revision : 1.0 - initial release
// ============================================================================
module div_unit #(
    parameter int BITS_PER_CYCLE = 1,
    parameter int META_W         = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              squash,
    input  logic [31:0]       rs1,
    input  logic [31:0]       rs2,
    input  logic [1:0]        func,
    input  logic [META_W-1:0] meta_in,
    output logic              ready,
    output logic              request,
    output logic              done,
    output logic [31:0]       result,
    output logic [META_W-1:0] meta_out
);

    localparam int ITER  = 32 / BITS_PER_CYCLE;
    localparam int CNT_W = 6;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_FIXUP = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state_q,    state_d;
    logic [CNT_W-1:0]    counter_q,  counter_d;
    logic [31:0]         rem_q,      rem_d;
    logic [31:0]         quo_q,      quo_d;
    logic [31:0]         divisor_q,  divisor_d;
    logic [31:0]         dividend_q, dividend_d;
    logic [1:0]          func_q,     func_d;
    logic                q_neg_q,    q_neg_d;
    logic                r_neg_q,    r_neg_d;
    logic                div_zero_q, div_zero_d;
    logic                overflow_q, overflow_d;
    logic [31:0]         result_q,   result_d;
    logic [META_W-1:0]   meta_q,     meta_d;
    logic                ready_q,    ready_d;
    logic                request_q,  request_d;
    logic                done_q,     done_d;

    logic [31:0] step_rem;
    logic [31:0] step_quo;
    logic [32:0] step_shift;
    logic [32:0] step_diff;
    logic        step_ok;

    logic        is_signed;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;
    logic [31:0] fix_result;
    logic        can_accept;

    // Restoring steps: the quotient bits shift into the dividend register as
    // its bits shift out into the partial remainder.
    always_comb begin
        step_rem   = rem_q;
        step_quo   = quo_q;
        step_shift = '0;
        step_diff  = '0;
        step_ok    = 1'b0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            step_shift = {step_rem, step_quo[31]};
            step_diff  = step_shift - {1'b0, divisor_q};
            step_ok    = step_shift[32] | ~step_diff[32];
            step_quo   = {step_quo[30:0], step_ok};
            step_rem   = step_ok ? step_diff[31:0] : step_shift[31:0];
        end
    end

    always_comb begin
        quo_fix = q_neg_q ? (32'd0 - quo_q) : quo_q;
        rem_fix = r_neg_q ? (32'd0 - rem_q) : rem_q;
        if (div_zero_q) begin
            quo_fix = 32'hFFFF_FFFF;
            rem_fix = dividend_q;
        end else if (overflow_q) begin
            quo_fix = 32'h8000_0000;
            rem_fix = 32'd0;
        end
        fix_result = func_q[1] ? rem_fix : quo_fix;
    end

    assign is_signed  = ~func[0];
    assign a_neg      = is_signed & rs1[31];
    assign b_neg      = is_signed & rs2[31];
    assign can_accept = (state_q == S_IDLE) || (state_q == S_DONE);

    always_comb begin
        state_d    = state_q;
        counter_d  = counter_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        divisor_d  = divisor_q;
        dividend_d = dividend_q;
        func_d     = func_q;
        q_neg_d    = q_neg_q;
        r_neg_d    = r_neg_q;
        div_zero_d = div_zero_q;
        overflow_d = overflow_q;
        result_d   = result_q;
        meta_d     = meta_q;

        if (squash) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_CALC: begin
                    rem_d     = step_rem;
                    quo_d     = step_quo;
                    counter_d = counter_q - 6'd1;
                    if (counter_q == 6'd1) begin
                        state_d = S_FIXUP;
                    end
                end
                S_FIXUP: begin
                    result_d = fix_result;
                    state_d  = S_DONE;
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = state_q;
            endcase

            if (start && can_accept) begin
                state_d    = S_CALC;
                counter_d  = CNT_W'(ITER);
                rem_d      = 32'd0;
                quo_d      = a_neg ? (32'd0 - rs1) : rs1;
                divisor_d  = b_neg ? (32'd0 - rs2) : rs2;
                dividend_d = rs1;
                func_d     = func;
                q_neg_d    = a_neg ^ b_neg;
                r_neg_d    = a_neg;
                div_zero_d = (rs2 == 32'd0);
                overflow_d = is_signed && (rs1 == 32'h8000_0000) && (rs2 == 32'hFFFF_FFFF);
                meta_d     = meta_in;
            end
        end

        ready_d   = (state_d == S_IDLE) || (state_d == S_DONE);
        request_d = (state_d == S_FIXUP);
        done_d    = (state_d == S_DONE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            counter_q  <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            divisor_q  <= '0;
            dividend_q <= '0;
            func_q     <= '0;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            div_zero_q <= 1'b0;
            overflow_q <= 1'b0;
            result_q   <= '0;
            meta_q     <= '0;
            ready_q    <= 1'b1;
            request_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            counter_q  <= counter_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            divisor_q  <= divisor_d;
            dividend_q <= dividend_d;
            func_q     <= func_d;
            q_neg_q    <= q_neg_d;
            r_neg_q    <= r_neg_d;
            div_zero_q <= div_zero_d;
            overflow_q <= overflow_d;
            result_q   <= result_d;
            meta_q     <= meta_d;
            ready_q    <= ready_d;
            request_q  <= request_d;
            done_q     <= done_d;
        end
    end

    assign ready    = ready_q;
    assign request  = request_q;
    assign done     = done_q;
    assign result   = result_q;
    assign meta_out = meta_q;

endmodule
`default_nettype wire
